// File: rtl/scr1_ahb_sram_resp.sv
// AHB-Lite SRAM responder for an SCR1 imem/dmem port: pipelined address/data phases,
// programmable OKAY wait states and two-cycle ERROR responses.
module scr1_ahb_sram_resp #(
    parameter int          MEM_POWER_SIZE = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          WAIT_STATES    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic        hready,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int         IDX_W   = MEM_POWER_SIZE - 2;
    localparam int         DEPTH   = 1 << IDX_W;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       lanes_q;
    logic             wr_q;
    logic             accept;
    logic             trans_valid;
    logic             acc_err;
    logic [3:0]       lanes;
    logic [31:0]      mem [DEPTH];

    // Address-phase decode: validity, error classification and byte-lane selection.
    always_comb begin
        trans_valid = htrans[1];
        acc_err     = (hsize > 3'd2)
                   || (hsize == 3'd1 && haddr[0])
                   || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                   || (haddr[31:MEM_POWER_SIZE] != BASE_ADDR[31:MEM_POWER_SIZE]);
        case (hsize)
            3'd0:    lanes = 4'b0001 << haddr[1:0];
            3'd1:    lanes = haddr[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hready   = 1'b0;
        hresp    = 1'b0;
        accept   = 1'b0;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                hready = 1'b1;
                hresp  = (state == ST_ERR2);
                accept = 1'b1;
                if (!trans_valid) begin
                    state_nx = ST_IDLE;
                end else if (acc_err) begin
                    state_nx = ST_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_nx = ST_DATA;
                end else begin
                    state_nx = ST_WAIT;
                    cnt_nx   = WS_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_nx = ST_DATA;
                else             cnt_nx   = cnt - 4'd1;
            end
            ST_ERR1: begin
                hresp    = 1'b1;
                state_nx = ST_ERR2;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            lanes_q <= 4'd0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                wr_q <= trans_valid && !acc_err && hwrite;
                if (trans_valid && !acc_err) begin
                    idx_q   <= haddr[MEM_POWER_SIZE-1:2];
                    lanes_q <= lanes;
                end
            end
        end
    end

    // NOTE: the array is deliberately left out of reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_DATA && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        hrdata = 32'd0;
        if (state == ST_DATA && !wr_q) hrdata = mem[idx_q];
    end

endmodule

// File: tb/tb_scr1_ahb_sram_resp.sv
// Scoreboard bench: a zero-wait and a two-wait responder share one bus driver; the driver
// queues the expected response per address phase and a monitor checks each data phase.
module tb_scr1_ahb_sram_resp;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  htrans = IDLE;
    logic [31:0] haddr = 32'd0;
    logic [2:0]  hsize = 3'd0;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = 32'd0;

    logic [1:0]  htrans0, htrans2;
    logic        hready0, hresp0, hready2, hresp2;
    logic [31:0] hrdata0, hrdata2;
    logic        m_hready, m_hresp;
    logic [31:0] m_hrdata;

    assign htrans0  = sel ? IDLE : htrans;
    assign htrans2  = sel ? htrans : IDLE;
    assign m_hready = sel ? hready2 : hready0;
    assign m_hresp  = sel ? hresp2  : hresp0;
    assign m_hrdata = sel ? hrdata2 : hrdata0;

    scr1_ahb_sram_resp #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .htrans(htrans0), .haddr(haddr), .hsize(hsize),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hready0), .hresp(hresp0), .hrdata(hrdata0)
    );

    scr1_ahb_sram_resp #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .htrans(htrans2), .haddr(haddr), .hsize(hsize),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hready2), .hresp(hresp2), .hrdata(hrdata2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  stalls;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every data-phase cycle of the oldest queued transfer is checked at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
            end else if (q.size() > 0) begin
                if (!m_hready) begin
                    stall_cnt++;
                    check("stall_hresp", {31'd0, m_hresp}, {31'd0, q[0].err});
                    check("stall_hrdata", m_hrdata, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("hresp", {31'd0, m_hresp}, {31'd0, e.err});
                    check("hrdata", m_hrdata, e.rdata);
                    check("stalls", 32'(stall_cnt), {28'd0, e.stalls});
                    stall_cnt = 0;
                end
            end
        end
    end

    // Called just after a posedge; returns just after the edge that sampled this address phase.
    task automatic issue(input logic [1:0] tr, input logic [31:0] addr, input logic [2:0] size,
                         input logic wr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata);
        exp_t e;
        int   n;
        htrans = tr;
        haddr  = addr;
        hsize  = size;
        hwrite = wr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_hready && n < 50);
        if (!m_hready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: hready still %b after %0d cycles, need 1", m_hready, n);
        end
        @(posedge clk);
        e.err    = err;
        e.rdata  = rdata;
        e.stalls = !tr[1] ? 4'd0 : err ? 4'd1 : sel ? 4'd2 : 4'd0;
        q.push_back(e);
        #1;
        hwdata = wdata;
        htrans = IDLE;
    endtask

    task automatic drain();
        int n;
        htrans = IDLE;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, need 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        htrans = IDLE;
        rst = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hready0", {31'd0, hready0}, 32'd1);
        check("rst_hresp0",  {31'd0, hresp0},  32'd0);
        check("rst_hrdata0", hrdata0, 32'd0);
        check("rst_hready2", {31'd0, hready2}, 32'd1);
        check("rst_hresp2",  {31'd0, hresp2},  32'd0);
        check("rst_hrdata2", hrdata2, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_pulse();

        // Zero-wait responder: word, byte and halfword writes with back-to-back reads.
        issue(NONSEQ, 32'h100, 3'd2, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(NONSEQ, 32'h100, 3'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF);
        issue(NONSEQ, 32'h103, 3'd0, 1'b1, 32'hAA000000, 1'b0, 32'h0);
        issue(NONSEQ, 32'h100, 3'd2, 1'b0, 32'h0,        1'b0, 32'hAAADBEEF);
        issue(NONSEQ, 32'h100, 3'd1, 1'b1, 32'h00001234, 1'b0, 32'h0);
        issue(NONSEQ, 32'h100, 3'd2, 1'b0, 32'h0,        1'b0, 32'hAAAD1234);

        // Error responses, then confirm the word is untouched.
        issue(NONSEQ, 32'h101,   3'd1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0);
        issue(NONSEQ, 32'h10000, 3'd2, 1'b0, 32'h0,        1'b1, 32'h0);
        issue(NONSEQ, 32'h100,   3'd3, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0);
        issue(NONSEQ, 32'h102,   3'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0);
        issue(NONSEQ, 32'h100,   3'd2, 1'b0, 32'h0,        1'b0, 32'hAAAD1234);

        // BUSY/IDLE interleaved with SEQ bursts; IDLE with an illegal address stays OKAY.
        issue(NONSEQ, 32'h104,      3'd2, 1'b1, 32'h11223344, 1'b0, 32'h0);
        issue(BUSY,   32'h108,      3'd2, 1'b1, 32'h0,        1'b0, 32'h0);
        issue(SEQ,    32'h108,      3'd2, 1'b1, 32'h55667788, 1'b0, 32'h0);
        issue(IDLE,   32'hFFFFFFFF, 3'd3, 1'b1, 32'h0,        1'b0, 32'h0);
        issue(NONSEQ, 32'h106,      3'd1, 1'b1, 32'h56780000, 1'b0, 32'h0);
        issue(NONSEQ, 32'h104,      3'd2, 1'b0, 32'h0,        1'b0, 32'h56783344);
        issue(BUSY,   32'h108,      3'd2, 1'b0, 32'h0,        1'b0, 32'h0);
        issue(SEQ,    32'h108,      3'd2, 1'b0, 32'h0,        1'b0, 32'h55667788);
        issue(NONSEQ, 32'h101,      3'd0, 1'b0, 32'h0,        1'b0, 32'hAAAD1234);
        issue(NONSEQ, 32'hFFFC,     3'd2, 1'b1, 32'h0F0F0F0F, 1'b0, 32'h0);
        issue(NONSEQ, 32'hFFFC,     3'd2, 1'b0, 32'h0,        1'b0, 32'h0F0F0F0F);
        drain();

        // Reset in the data phase of a write: the write must be dropped.
        issue(NONSEQ, 32'h100, 3'd2, 1'b1, 32'hBAD0BAD0, 1'b0, 32'h0);
        reset_pulse();
        issue(NONSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 1'b0, 32'hAAAD1234);
        drain();

        // Two-wait responder.
        sel = 1'b1;
        issue(NONSEQ, 32'h100,   3'd2, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0);
        issue(NONSEQ, 32'h100,   3'd2, 1'b0, 32'h0,        1'b0, 32'hCAFEF00D);
        issue(NONSEQ, 32'h10000, 3'd2, 1'b0, 32'h0,        1'b1, 32'h0);
        issue(IDLE,   32'h100,   3'd2, 1'b0, 32'h0,        1'b0, 32'h0);
        issue(NONSEQ, 32'h102,   3'd0, 1'b0, 32'h0,        1'b0, 32'hCAFEF00D);
        drain();

        // Reset while a write sits in its wait states.
        issue(NONSEQ, 32'h100, 3'd2, 1'b1, 32'h11111111, 1'b0, 32'h0);
        reset_pulse();
        issue(NONSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
